// File: rtl/fp_stft_frame_sched_pkg.sv
// Shared constants, FSM encoding and hop clamping for the STFT frame scheduler.
package fp_stft_pkg;

    localparam int F      = 4;
    localparam int IDX_W  = 2;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RES = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    // Zero and anything past the frame size collapse to a non-overlapping hop.
    function automatic logic [2:0] clamp_hop(input logic [2:0] hop);
        return ((hop == 3'd0) || (hop > 3'(F))) ? 3'(F) : hop;
    endfunction

endpackage

// File: rtl/fp_stft_frame_sched_if.sv
// Sample, frame, result and bin channels of the STFT frame scheduler.
interface fp_stft_frame_sched_if;
    import fp_stft_pkg::*;

    logic [2:0]          hop;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   re_in;
    logic [DATA_W-1:0]   im_in;
    logic                frm_valid;
    logic                frm_ready;
    logic [F*DATA_W-1:0] frm_re;
    logic [F*DATA_W-1:0] frm_im;
    logic                res_valid;
    logic [F*DATA_W-1:0] res_re;
    logic [F*DATA_W-1:0] res_im;
    logic                bin_valid;
    logic                bin_ready;
    logic [DATA_W-1:0]   bin_re;
    logic [DATA_W-1:0]   bin_im;
    logic [IDX_W-1:0]    bin_idx;
    logic                bin_last;
    logic [15:0]         frame_idx;
    logic                err_res;

    modport slave (
        input  hop, in_valid, re_in, im_in, frm_ready, res_valid, res_re, res_im, bin_ready,
        output in_ready, frm_valid, frm_re, frm_im, bin_valid, bin_re, bin_im, bin_idx,
               bin_last, frame_idx, err_res
    );

    modport master (
        output hop, in_valid, re_in, im_in, frm_ready, res_valid, res_re, res_im, bin_ready,
        input  in_ready, frm_valid, frm_re, frm_im, bin_valid, bin_re, bin_im, bin_idx,
               bin_last, frame_idx, err_res
    );

endinterface

// File: rtl/fp_stft_frame_sched_win_buf.sv
// Sliding sample window: circular buffer, accept/issue qualification, oldest-first view.
module fp_stft_win_buf
    import fp_stft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   re_in,
    input  logic [DATA_W-1:0]   im_in,
    input  logic [2:0]          hop_r,
    input  logic                snap,
    output logic                in_ready,
    output logic                issue_ok,
    output logic [F*DATA_W-1:0] win_re,
    output logic [F*DATA_W-1:0] win_im
);

    logic [DATA_W-1:0] buf_re [F];
    logic [DATA_W-1:0] buf_im [F];
    logic [IDX_W-1:0]  wp;
    logic [2:0]        fill_cnt;
    logic [2:0]        new_cnt;
    logic              accept;

    assign in_ready = (fill_cnt < 3'(F)) || (new_cnt < hop_r);
    assign accept   = in_valid && in_ready;
    assign issue_ok = (fill_cnt == 3'(F)) && (new_cnt >= hop_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < F; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
            wp       <= '0;
            fill_cnt <= '0;
            new_cnt  <= '0;
        end else begin
            if (accept) begin
                buf_re[wp] <= re_in;
                buf_im[wp] <= im_in;
                wp         <= wp + 1'b1;
                if (fill_cnt != 3'(F)) fill_cnt <= fill_cnt + 3'd1;
            end
            // A sample landing on the snapshot edge is the first of the next frame.
            if (snap)
                new_cnt <= accept ? 3'd1 : 3'd0;
            else if (accept && (new_cnt < 3'(F)))
                new_cnt <= new_cnt + 3'd1;
        end
    end

    // The slot at wp is the oldest entry once the buffer has wrapped.
    always_comb begin
        win_re = '0;
        win_im = '0;
        for (int k = 0; k < F; k++) begin
            win_re[DATA_W*k +: DATA_W] = buf_re[wp + IDX_W'(k)];
            win_im[DATA_W*k +: DATA_W] = buf_im[wp + IDX_W'(k)];
        end
    end

endmodule

// File: rtl/fp_stft_frame_sched.sv
// STFT frame scheduler: issues overlapping 4-sample frames and serializes 4-bin results.
module fp_stft_frame_sched
    import fp_stft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fp_stft_frame_sched_if.slave  bus
);

    logic [1:0]          state;
    logic [2:0]          hop_r;
    logic [IDX_W-1:0]    k;
    logic [15:0]         frame_cnt;
    logic                err_r;
    logic [F*DATA_W-1:0] frm_re_r;
    logic [F*DATA_W-1:0] frm_im_r;
    logic [F*DATA_W-1:0] res_re_r;
    logic [F*DATA_W-1:0] res_im_r;
    logic [F*DATA_W-1:0] win_re;
    logic [F*DATA_W-1:0] win_im;
    logic                issue_ok;
    logic                snap;

    assign snap = (state == ST_IDLE) && issue_ok;

    fp_stft_win_buf u_win (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .re_in    (bus.re_in),
        .im_in    (bus.im_in),
        .hop_r    (hop_r),
        .snap     (snap),
        .in_ready (bus.in_ready),
        .issue_ok (issue_ok),
        .win_re   (win_re),
        .win_im   (win_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hop_r     <= 3'(F);
            k         <= '0;
            frame_cnt <= '0;
            err_r     <= 1'b0;
            frm_re_r  <= '0;
            frm_im_r  <= '0;
            res_re_r  <= '0;
            res_im_r  <= '0;
        end else begin
            if (state == ST_IDLE) hop_r <= clamp_hop(bus.hop);
            if (bus.res_valid && (state != ST_WAIT_RES)) err_r <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (issue_ok) begin
                        frm_re_r <= win_re;
                        frm_im_r <= win_im;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.frm_ready) state <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    if (bus.res_valid) begin
                        res_re_r <= bus.res_re;
                        res_im_r <= bus.res_im;
                        k        <= '0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.bin_ready) begin
                        k <= k + 1'b1;
                        if (k == IDX_W'(F-1)) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.frm_valid = (state == ST_ISSUE);
    assign bus.frm_re    = frm_re_r;
    assign bus.frm_im    = frm_im_r;
    assign bus.bin_valid = (state == ST_DRAIN);
    assign bus.bin_re    = res_re_r[DATA_W*k +: DATA_W];
    assign bus.bin_im    = res_im_r[DATA_W*k +: DATA_W];
    assign bus.bin_idx   = k;
    assign bus.bin_last  = (state == ST_DRAIN) && (k == IDX_W'(F-1));
    assign bus.frame_idx = frame_cnt;
    assign bus.err_res   = err_r;

endmodule
